alu_cdb_unit: RTL
=================

# alu_cdb_unit

Registered, parametrised integer execution unit that sits between the ALU reservation station and the common data bus (CDB). It accepts one issued instruction per cycle under a valid/ready handshake and computes the integer, branch and jump result one cycle later. Results are held in a small output queue until the CDB arbiter grants them, so the unit never loses a result when the bus is busy. ROB-driven flush discards all in-flight work.

## Interface
Parameters:
- XLEN, 32, datapath and address width.
- ROB_W, 4, ROB index (rename tag) width.
- OP_W, 6, width of the ALU op code (encodings from the shared package).
- QDEPTH, 2, output queue depth; must be a power of two and at least 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; when low, all state is frozen.
- flush  in  1  ROB rollback; discards all accepted, unbroadcast work.
- in_valid  in  1  reservation station presents an instruction.
- in_ready  out  1  unit can accept; defined as `rdy && !rst && !mul_busy && count < QDEPTH`.
- in_rob  in  ROB_W  destination rename tag.
- in_pc  in  XLEN  instruction PC.
- in_imm  in  XLEN  immediate, already sign-extended by the decoder.
- in_rs1, in_rs2  in  XLEN  resolved operand values.
- in_op  in  OP_W  operation code.
- cdb_valid  out  1  queue head is valid.
- cdb_grant  in  1  arbiter accepts the head this cycle.
- cdb_rob  out  ROB_W  tag of the head entry.
- cdb_value  out  XLEN  result value (0 for branches).
- cdb_is_br  out  1  head entry is a conditional branch; no register write.
- cdb_taken  out  1  branch condition true, or 1 for JAL/JALR.
- cdb_target  out  XLEN  jump or branch target.

## Operation
- An instruction is accepted when in_valid and in_ready are both high at a clock edge. The result is computed combinationally from the input operands and pushed into the queue at that same edge.
- Arithmetic and logic ops:
  - ADD/ADDI/SUB, XOR/OR/AND and their immediate forms.
  - LUI gives imm.
  - AUIPC gives pc+imm.
  - SLT/SLTI are signed compares; SLTU/SLTIU are unsigned compares.
  - Shifts use only the low log2(XLEN) bits of the shift amount. SRA/SRAI are arithmetic shifts of the signed rs1.
- Branches BEQ/BNE/BLT/BGE/BLTU/BGEU:
  - cdb_is_br=1, cdb_value=0.
  - cdb_taken is the condition result.
  - cdb_target = pc+imm.
- JAL:
  - value = pc+4, taken=1, target = pc+imm.
- JALR:
  - value = pc+4, taken=1, target = (rs1+imm) with bit 0 cleared.
- An undefined op code produces an entry with value 0, taken 0 and target 0.
- The queue is a FIFO that pops when cdb_valid && cdb_grant && rdy.
  - A push and a pop in the same cycle are allowed; count is unchanged.
  - Full is reached at count==QDEPTH; in_ready then drops on the following cycle.
  - Empty means cdb_valid=0.
  - Pointers wrap modulo QDEPTH.
- Priority, highest first:
  - rst clears everything.
  - flush clears the queue, the multiplier state and any same-cycle accept; a same-cycle grant is ignored.
  - !rdy holds all state; in_ready=0 and grants are ignored. cdb_* outputs keep their value.
- All arithmetic wraps modulo 2^XLEN; no overflow flag.

## Timing
- Reset values:
  - in_ready=0 during the rst cycle.
  - cdb_valid=0, cdb_rob=0, cdb_value=0, cdb_is_br=0, cdb_taken=0, cdb_target=0.
  - count=0, both pointers 0, mul_busy=0.
- Latency: an instruction accepted at edge N appears on cdb_* after edge N (visible in cycle N+1).
- Throughput is 1 instruction per cycle while the queue is not full.
- cdb_* outputs are driven from registers only. There is no combinational path from in_* or cdb_grant to any output except in_ready.
- A flush asserted at edge N makes cdb_valid 0 from cycle N+1.

## Configuration
- ALU_MUL_EN defined:
  - Adds MUL, MULH, MULHSU and MULHU through an internal 2-stage multiplier.
  - Accept at edge N; result is pushed at edge N+2.
  - mul_busy is high from accept until the push, so in_ready=0 during that time. Non-multiply ops never overlap with a multiply.
  - The multiply path requires count < QDEPTH at accept and reserves that slot.
- ALU_MUL_EN undefined:
  - The multiply op codes are treated as undefined ops.
  - mul_busy is tied to 0.

## Structure
- Package alu_pkg holds:
  - the op code localparams (ADD … JALR, MUL…);
  - default widths (XLEN, ROB_W);
  - the packed result-entry typedef {rob, value, is_br, taken, target}.
- Sub-module alu_result_queue is a parametrised synchronous FIFO of entries with push/pop/flush ports and full/empty/count outputs. The compute logic remains in alu_cdb_unit.

## Test plan
- ADDI rs1=0xFFFFFFFF, imm=1, rob=3, grant held high -> cycle N+1: cdb_valid=1, rob=3, value=0x0, is_br=0.
- Push 3 ops with grant low and QDEPTH=2 -> in_ready=0 after 2 accepts; raise grant -> entries drain in order; third op accepted once count<2.
- BLT rs1=0xFFFFFFFE, rs2=1, pc=0x100, imm=-8 -> is_br=1, taken=1, target=0xF8. Repeat as BLTU -> taken=0.
- JALR rs1=0x1003, imm=2, pc=0x40 -> value=0x44, target=0x1004, taken=1.
- Two entries queued, then flush with a simultaneous in_valid and grant -> cdb_valid=0 next cycle, count=0, nothing accepted. rdy low for 3 cycles mid-stream -> outputs frozen, no loss or duplication.
- With ALU_MUL_EN: MULHU 0xFFFFFFFF×0xFFFFFFFF -> value=0xFFFFFFFE at N+3, in_ready=0 for 2 cycles. Without ALU_MUL_EN: the same op -> value=0 at N+1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, default widths and the CDB result-entry type for the ALU execution unit.
package alu_pkg;
  localparam int XLEN_DEF = 32;
  localparam int ROB_W_DEF = 4;
  localparam int OP_W_DEF = 6;
  localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_XOR = 6'd2, OP_OR = 6'd3, OP_AND = 6'd4,
    OP_SLL = 6'd5, OP_SRL = 6'd6, OP_SRA = 6'd7, OP_SLT = 6'd8, OP_SLTU = 6'd9,
    OP_ADDI = 6'd10, OP_XORI = 6'd11, OP_ORI = 6'd12, OP_ANDI = 6'd13, OP_SLLI = 6'd14,
    OP_SRLI = 6'd15, OP_SRAI = 6'd16, OP_SLTI = 6'd17, OP_SLTIU = 6'd18, OP_LUI = 6'd19,
    OP_AUIPC = 6'd20, OP_BEQ = 6'd21, OP_BNE = 6'd22, OP_BLT = 6'd23, OP_BGE = 6'd24,
    OP_BLTU = 6'd25, OP_BGEU = 6'd26, OP_JAL = 6'd27, OP_JALR = 6'd28,
    OP_MUL = 6'd29, OP_MULH = 6'd30, OP_MULHSU = 6'd31, OP_MULHU = 6'd32;
  typedef struct packed {
    logic [ROB_W_DEF-1:0] rob;
    logic [XLEN_DEF-1:0]  value;
    logic                 is_br;
    logic                 taken;
    logic [XLEN_DEF-1:0]  target;
  } alu_entry_t;
endpackage

// File: rtl/alu_cdb_unit_queue.sv
// alu_result_queue: synchronous FIFO of result entries; flush empties it, rdy low freezes it.
module alu_result_queue import alu_pkg::*; #(
  parameter type T = alu_entry_t,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  T mem_q [DEPTH];
  T mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign count = cnt_q;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = empty ? '0 : mem_q[rd_q];
  always_comb begin
    mem_d = mem_q;
    wr_d = wr_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
      cnt_d = '0;
    end else if (rdy) begin
      if (push) mem_d[wr_q] = din;
      wr_d = push ? wr_q + PW'(1) : wr_q;
      rd_d = pop ? rd_q + PW'(1) : rd_q;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_cdb_unit.sv
// alu_cdb_unit: integer/branch/jump execution unit buffering results for the CDB; ALU_MUL_EN adds a 2-stage multiplier.
module alu_cdb_unit import alu_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int ROB_W = ROB_W_DEF,
  parameter int OP_W = OP_W_DEF,
  parameter int QDEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROB_W-1:0] in_rob,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [OP_W-1:0]  in_op,
  output logic             cdb_valid,
  input  logic             cdb_grant,
  output logic [ROB_W-1:0] cdb_rob,
  output logic [XLEN-1:0]  cdb_value,
  output logic             cdb_is_br,
  output logic             cdb_taken,
  output logic [XLEN-1:0]  cdb_target
);
  localparam int SH = $clog2(XLEN);
  typedef struct packed {
    logic [ROB_W-1:0] rob;
    logic [XLEN-1:0]  value;
    logic             is_br;
    logic             taken;
    logic [XLEN-1:0]  target;
  } entry_t;
  entry_t alu_e, mul_e, push_e, head_e;
  logic full, empty, accept, pop, q_push, is_mul, mul_busy, mul_push, br_cond;
  logic [$clog2(QDEPTH):0] count;
  logic [XLEN-1:0] pc_imm;
  logic [SH-1:0] sh_r, sh_i;
  assign in_ready = rdy && !rst && !mul_busy && (int'(count) < QDEPTH);
  assign accept = in_valid && in_ready && !flush;
  assign pop = !empty && cdb_grant && rdy;
  assign q_push = ((accept && !is_mul) || mul_push) && !full;
  assign push_e = mul_push ? mul_e : alu_e;
  assign pc_imm = in_pc + in_imm;
  assign sh_r = in_rs2[SH-1:0];
  assign sh_i = in_imm[SH-1:0];
  assign br_cond = in_op == OP_BEQ ? in_rs1 == in_rs2 :
                   in_op == OP_BNE ? in_rs1 != in_rs2 :
                   in_op == OP_BLT ? $signed(in_rs1) < $signed(in_rs2) :
                   in_op == OP_BGE ? $signed(in_rs1) >= $signed(in_rs2) :
                   in_op == OP_BLTU ? in_rs1 < in_rs2 : in_rs1 >= in_rs2;
  always_comb begin
    alu_e = '0;
    alu_e.rob = in_rob;
    case (in_op)
      OP_ADD:   alu_e.value = in_rs1 + in_rs2;
      OP_SUB:   alu_e.value = in_rs1 - in_rs2;
      OP_XOR:   alu_e.value = in_rs1 ^ in_rs2;
      OP_OR:    alu_e.value = in_rs1 | in_rs2;
      OP_AND:   alu_e.value = in_rs1 & in_rs2;
      OP_SLL:   alu_e.value = in_rs1 << sh_r;
      OP_SRL:   alu_e.value = in_rs1 >> sh_r;
      OP_SRA:   alu_e.value = $signed(in_rs1) >>> sh_r;
      OP_SLT:   alu_e.value = XLEN'($signed(in_rs1) < $signed(in_rs2));
      OP_SLTU:  alu_e.value = XLEN'(in_rs1 < in_rs2);
      OP_ADDI:  alu_e.value = in_rs1 + in_imm;
      OP_XORI:  alu_e.value = in_rs1 ^ in_imm;
      OP_ORI:   alu_e.value = in_rs1 | in_imm;
      OP_ANDI:  alu_e.value = in_rs1 & in_imm;
      OP_SLLI:  alu_e.value = in_rs1 << sh_i;
      OP_SRLI:  alu_e.value = in_rs1 >> sh_i;
      OP_SRAI:  alu_e.value = $signed(in_rs1) >>> sh_i;
      OP_SLTI:  alu_e.value = XLEN'($signed(in_rs1) < $signed(in_imm));
      OP_SLTIU: alu_e.value = XLEN'(in_rs1 < in_imm);
      OP_LUI:   alu_e.value = in_imm;
      OP_AUIPC: alu_e.value = pc_imm;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        alu_e.is_br = 1'b1;
        alu_e.taken = br_cond;
        alu_e.target = pc_imm;
      end
      OP_JAL: begin
        alu_e.value = in_pc + XLEN'(4);
        alu_e.taken = 1'b1;
        alu_e.target = pc_imm;
      end
      OP_JALR: begin
        alu_e.value = in_pc + XLEN'(4);
        alu_e.taken = 1'b1;
        alu_e.target = (in_rs1 + in_imm) & ~XLEN'(1);
      end
      default: ;
    endcase
  end
`ifdef ALU_MUL_EN
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d, hi_q, hi_d;
  logic [ROB_W-1:0] r1_q, r1_d, r2_q, r2_d;
  logic [2*XLEN-1:0] a_q, a_d, b_q, b_d, prod;
  logic [XLEN-1:0] p_q, p_d;
  assign is_mul = in_op == OP_MUL || in_op == OP_MULH || in_op == OP_MULHSU || in_op == OP_MULHU;
  assign mul_busy = s1_v_q || s2_v_q;
  assign mul_push = s2_v_q && rdy && !flush;
  assign mul_e = {r2_q, p_q, 1'b0, 1'b0, XLEN'(0)};
  // Operands are sign- or zero-extended to 2*XLEN so one unsigned multiply serves every variant.
  assign prod = a_q * b_q;
  always_comb begin
    s1_v_d = s1_v_q;
    s2_v_d = s2_v_q;
    hi_d = hi_q;
    r1_d = r1_q;
    r2_d = r2_q;
    a_d = a_q;
    b_d = b_q;
    p_d = p_q;
    if (flush) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end else if (rdy) begin
      s2_v_d = s1_v_q;
      r2_d = r1_q;
      p_d = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
      s1_v_d = accept && is_mul;
      r1_d = in_rob;
      hi_d = in_op != OP_MUL;
      a_d = {{XLEN{in_rs1[XLEN-1] && in_op != OP_MULHU}}, in_rs1};
      b_d = {{XLEN{in_rs2[XLEN-1] && (in_op == OP_MULH || in_op == OP_MUL)}}, in_rs2};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      hi_q <= 1'b0;
      r1_q <= '0;
      r2_q <= '0;
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      hi_q <= hi_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
    end
  end
`else
  assign is_mul = 1'b0;
  assign mul_busy = 1'b0;
  assign mul_push = 1'b0;
  assign mul_e = '0;
`endif
  alu_result_queue #(.T(entry_t), .DEPTH(QDEPTH)) u_queue (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .push(q_push), .pop(pop),
    .din(push_e), .dout(head_e), .full(full), .empty(empty), .count(count)
  );
  assign cdb_valid = !empty;
  assign cdb_rob = head_e.rob;
  assign cdb_value = head_e.value;
  assign cdb_is_br = head_e.is_br;
  assign cdb_taken = head_e.taken;
  assign cdb_target = head_e.target;
endmodule
